mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage of the pipelined LEGv8 core, and the consumer end of the execute stage's outputs (EX/MEM contents).
- Takes the ALU result as address, the store data, and the branch/zero flags, and computes PCSrc.
- Runs load/store requests to a multi-cycle data memory through a req/ready handshake, stalling upstream while an access is pending.
- Drives the MEM/WB pipeline register.

Parameters:
N, 64, data/address width
TIMEOUT, 255, max ACCESS cycles without mem_ready before abort (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
valid_M  in  1  EX/MEM entry holds a real instruction
MemRead_M  in  1  load
MemWrite_M  in  1  store
Branch_M  in  1  conditional branch (CBZ)
zero_M  in  1  ALU zero flag
aluResult_M  in  N  ALU result / memory address
writeData_M  in  N  store data
PCSrc_M  out  1  take branch
stall_M  out  1  hold all upstream stages and EX/MEM
mem_req  out  1  memory request
mem_we  out  1  1=write, 0=read
mem_addr  out  N  request address
mem_wdata  out  N  store data
mem_ready  in  1  memory completes the request this cycle
mem_rdata  in  N  load data, valid when mem_ready=1
valid_W  out  1  MEM/WB holds an instruction
aluResult_W  out  N  registered aluResult_M
readData_W  out  N  load data, 0 for non-loads
align_err_W  out  1  misaligned memory op
bus_err_W  out  1  access timed out

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. On reset: state=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, and all *_W outputs=0.
- memop = valid_M & (MemRead_M | MemWrite_M). aligned = (aluResult_M[2:0]==0). If both MemRead_M and MemWrite_M are set, treat the op as a store.
- PCSrc_M = valid_M & Branch_M & zero_M. Purely combinational, independent of state.
- stall_M (combinational) = (IDLE & memop & aligned) | (ACCESS & !mem_ready & counter<TIMEOUT-1).
- IDLE, when !memop or misaligned:
  - At the edge, MEM/WB loads valid_W=valid_M, aluResult_W=aluResult_M, readData_W=0, bus_err_W=0.
  - align_err_W = memop & !aligned.
  - No mem_req is issued; a misaligned store is suppressed.
  - Latency is 1 cycle.
- IDLE, when memop & aligned:
  - At the edge, go to ACCESS.
  - Latch mem_addr=aluResult_M, mem_wdata=writeData_M, mem_we=MemWrite_M, mem_req=1, counter=0.
  - MEM/WB loads a bubble (valid_W=0, others 0).
- ACCESS:
  - mem_req=1 and mem_addr/mem_wdata/mem_we are held stable until the request ends.
  - counter increments each cycle mem_ready=0.
- ACCESS, when mem_ready=1:
  - stall_M=0 that cycle, so upstream advances at the same edge.
  - MEM/WB loads valid_W=1, aluResult_W=mem_addr, readData_W = mem_we ? 0 : mem_rdata, both error flags 0.
  - mem_req=0, go to IDLE.
  - Minimum load/store latency: 2 cycles from arrival to valid_W.
- ACCESS timeout (mem_ready=0 and counter==TIMEOUT-1):
  - stall_M=0.
  - MEM/WB loads valid_W=1, readData_W=0, bus_err_W=1, aluResult_W=mem_addr.
  - mem_req=0, go to IDLE.
  - A late mem_ready is ignored.
- mem_ready is ignored in IDLE.
- mem_ready and timeout on the same cycle: mem_ready wins, no error.
- Counter width is clog2(TIMEOUT+1). It never wraps, because it is cleared on entry to ACCESS.
- Reset mid-ACCESS: mem_req drops at that edge, and the pending result is discarded (valid_W=0).
- Back-to-back memory ops: the next op enters IDLE→ACCESS the cycle after completion. There is always one bubble between consecutive memory results.

Test Plan:
- Reset asserted 2 cycles during ACCESS → next cycle mem_req=0, valid_W=0, stall_M=0, every *_W output 0.
- ALU op, valid_M=1, aluResult_M=0x2A, no memop → next edge valid_W=1, aluResult_W=0x2A, readData_W=0, mem_req never 1, stall_M=0 throughout.
- Load at addr 0x100, mem_ready after 3 ACCESS cycles with mem_rdata=0xDEADBEEF → stall_M=1 for 4 cycles; mem_addr=0x100 and mem_we=0 stable; valid_W=1, readData_W=0xDEADBEEF, aluResult_W=0x100.
- Store addr 0x8, data 0x55, ready on first ACCESS cycle → mem_we=1, mem_wdata=0x55; valid_W at 2nd edge with readData_W=0; then CBZ with zero_M=1 → PCSrc_M=1 combinationally.
- Misaligned store to 0x104 → no mem_req; align_err_W=1 next edge; stall_M=0.
- TIMEOUT=4, mem_ready held 0 → mem_req high exactly 4 cycles; then bus_err_W=1, valid_W=1, readData_W=0; a mem_ready pulse one cycle later is ignored.

Source files
------------

// File: rtl/mem_access.sv
// Memory stage of the pipelined LEGv8 core.
// Consumes the EX/MEM contents, resolves CBZ into PCSrc_M, runs aligned loads and
// stores against a multi-cycle data memory via a req/ready handshake with a
// timeout, and drives the MEM/WB pipeline register.
module mem_access #(
    parameter int unsigned N       = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    // EX/MEM contents
    input  logic         valid_M,
    input  logic         MemRead_M,
    input  logic         MemWrite_M,
    input  logic         Branch_M,
    input  logic         zero_M,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] writeData_M,
    // Pipeline control
    output logic         PCSrc_M,
    output logic         stall_M,
    // Data memory request/response
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [N-1:0] mem_rdata,
    // MEM/WB register
    output logic         valid_W,
    output logic [N-1:0] aluResult_W,
    output logic [N-1:0] readData_W,
    output logic         align_err_W,
    output logic         bus_err_W
);

    // Counter only ever reaches TIMEOUT-1, so this width never wraps.
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LastCnt = CW'(TIMEOUT - 1);

    typedef enum logic {
        StIdle,
        StAccess
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           req_q, req_d;
    logic           we_q, we_d;
    logic [N-1:0]   addr_q, addr_d;
    logic [N-1:0]   wdata_q, wdata_d;

    logic           valid_w_q, valid_w_d;
    logic [N-1:0]   alu_w_q, alu_w_d;
    logic [N-1:0]   rdata_w_q, rdata_w_d;
    logic           align_w_q, align_w_d;
    logic           bus_w_q, bus_w_d;

    logic           memop;
    logic           aligned;
    logic           last_cycle;

    // Decode of the incoming EX/MEM entry.
    always_comb begin
        memop      = valid_M & (MemRead_M | MemWrite_M);
        aligned    = (aluResult_M[2:0] == 3'b000);
        last_cycle = (cnt_q == LastCnt);
    end

    // Branch resolution and upstream hold; both are independent of the result path.
    always_comb begin
        PCSrc_M = valid_M & Branch_M & zero_M;
        stall_M = 1'b0;
        unique case (state_q)
            StIdle:   stall_M = memop & aligned;
            StAccess: stall_M = ~mem_ready & (cnt_q < LastCnt);
            default:  stall_M = 1'b0;
        endcase
    end

    // Next-state, request and MEM/WB logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        valid_w_d = 1'b0;
        alu_w_d   = '0;
        rdata_w_d = '0;
        align_w_d = 1'b0;
        bus_w_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_d = 1'b0;
                if (memop && aligned) begin
                    // Launch the access; a set MemWrite_M makes it a store even
                    // when MemRead_M is also set. MEM/WB takes a bubble.
                    state_d = StAccess;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = MemWrite_M;
                    addr_d  = aluResult_M;
                    wdata_d = writeData_M;
                end else begin
                    // Non-memory op, bubble, or misaligned op (suppressed).
                    valid_w_d = valid_M;
                    alu_w_d   = aluResult_M;
                    align_w_d = memop & ~aligned;
                end
            end

            StAccess: begin
                if (mem_ready) begin
                    // Ready beats a coincident timeout.
                    state_d   = StIdle;
                    req_d     = 1'b0;
                    valid_w_d = 1'b1;
                    alu_w_d   = addr_q;
                    rdata_w_d = we_q ? '0 : mem_rdata;
                end else if (last_cycle) begin
                    state_d   = StIdle;
                    req_d     = 1'b0;
                    valid_w_d = 1'b1;
                    alu_w_d   = addr_q;
                    bus_w_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            valid_w_q <= 1'b0;
            alu_w_q   <= '0;
            rdata_w_q <= '0;
            align_w_q <= 1'b0;
            bus_w_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            valid_w_q <= valid_w_d;
            alu_w_q   <= alu_w_d;
            rdata_w_q <= rdata_w_d;
            align_w_q <= align_w_d;
            bus_w_q   <= bus_w_d;
        end
    end

    // Registered outputs.
    always_comb begin
        mem_req     = req_q;
        mem_we      = we_q;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        valid_W     = valid_w_q;
        aluResult_W = alu_w_q;
        readData_W  = rdata_w_q;
        align_err_W = align_w_q;
        bus_err_W   = bus_w_q;
    end

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: randomized instruction stream, a memory responder
// with planned latencies, and a scoreboard of expected MEM/WB results.
module tb_mem_access;

    localparam int unsigned N       = 64;
    localparam int unsigned TIMEOUT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_M, MemRead_M, MemWrite_M, Branch_M, zero_M;
    logic [N-1:0] aluResult_M, writeData_M;
    logic         PCSrc_M, stall_M;
    logic         mem_req, mem_we;
    logic [N-1:0] mem_addr, mem_wdata;
    logic         mem_ready;
    logic [N-1:0] mem_rdata;
    logic         valid_W;
    logic [N-1:0] aluResult_W, readData_W;
    logic         align_err_W, bus_err_W;

    mem_access #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_M     (valid_M),
        .MemRead_M   (MemRead_M),
        .MemWrite_M  (MemWrite_M),
        .Branch_M    (Branch_M),
        .zero_M      (zero_M),
        .aluResult_M (aluResult_M),
        .writeData_M (writeData_M),
        .PCSrc_M     (PCSrc_M),
        .stall_M     (stall_M),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .valid_W     (valid_W),
        .aluResult_W (aluResult_W),
        .readData_W  (readData_W),
        .align_err_W (align_err_W),
        .bus_err_W   (bus_err_W)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] alu;
        logic [N-1:0] rdata;
        logic         align;
        logic         bus;
    } exp_t;

    typedef struct {
        logic         we;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
        int           delay;   // ACCESS cycles before ready; >= TIMEOUT means never
        logic [N-1:0] rdata;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: every valid MEM/WB entry must match the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && valid_W === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail_now("spurious_valid_W");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("aluResult_W", aluResult_W, e.alu);
                    chk("readData_W", readData_W, e.rdata);
                    chk("align_err_W", N'(align_err_W), N'(e.align));
                    chk("bus_err_W", N'(bus_err_W), N'(e.bus));
                end
            end
        end
    end

    // Memory responder: serves requests in order with their planned latency and
    // checks the request fields; pulses a stray ready right after each request.
    initial begin
        req_t r;
        bit   cur;
        int   idx;
        cur       = 1'b0;
        idx       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                cur       = 1'b0;
                mem_ready = 1'b0;
            end else if (mem_req) begin
                if (!cur) begin
                    if (req_q.size() == 0) begin
                        fail_now("unexpected_mem_req");
                    end else begin
                        r   = req_q.pop_front();
                        cur = 1'b1;
                        idx = 0;
                    end
                end
                if (cur) begin
                    chk("mem_addr", mem_addr, r.addr);
                    chk("mem_we", N'(mem_we), N'(r.we));
                    chk("mem_wdata", mem_wdata, r.wdata);
                    mem_ready = (idx == r.delay);
                    mem_rdata = mem_ready ? r.rdata : {$urandom, $urandom};
                    idx++;
                end else begin
                    mem_ready = 1'b0;
                end
            end else begin
                if (cur) begin
                    chk("mem_req_cycles", N'(idx),
                        N'((r.delay < int'(TIMEOUT)) ? r.delay + 1 : int'(TIMEOUT)));
                    cur       = 1'b0;
                    mem_ready = 1'b1;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                mem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Present one instruction and hold it until the stage accepts it.
    task automatic issue(input logic v, input logic rd, input logic wr, input logic br,
                         input logic z, input logic [N-1:0] addr, input logic [N-1:0] wd,
                         input int delay, input logic [N-1:0] rdata);
        bit   memop, aligned, s;
        int   exp_stall, stalls;
        exp_t e;
        req_t r;
        valid_M     = v;
        MemRead_M   = rd;
        MemWrite_M  = wr;
        Branch_M    = br;
        zero_M      = z;
        aluResult_M = addr;
        writeData_M = wd;

        memop   = v && (rd || wr);
        aligned = (addr % 8) == 0;
        e.alu   = addr;
        e.rdata = '0;
        e.align = 1'b0;
        e.bus   = 1'b0;
        exp_stall = 0;
        if (memop && aligned) begin
            r.we    = wr;
            r.addr  = addr;
            r.wdata = wd;
            r.delay = delay;
            r.rdata = rdata;
            req_q.push_back(r);
            if (delay < int'(TIMEOUT)) begin
                exp_stall = delay + 1;
                if (!wr) e.rdata = rdata;
            end else begin
                exp_stall = int'(TIMEOUT);
                e.bus     = 1'b1;
            end
            exp_q.push_back(e);
        end else if (v) begin
            e.align = memop;
            exp_q.push_back(e);
        end

        stalls = 0;
        @(negedge clk);
        chk("PCSrc_M", N'(PCSrc_M), N'(v && br && z));
        forever begin
            s = stall_M;
            @(posedge clk);
            #1;
            if (!s) break;
            stalls++;
            if (stalls > 100) begin
                fail_now("stall_timeout");
                break;
            end
            @(negedge clk);
        end
        chk("stall_cycles", N'(stalls), N'(exp_stall));
    endtask

    task automatic idle_inputs();
        valid_M    = 1'b0;
        MemRead_M  = 1'b0;
        MemWrite_M = 1'b0;
        Branch_M   = 1'b0;
        zero_M     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_req"}, N'(mem_req), '0);
        chk({tag, "_stall_M"}, N'(stall_M), '0);
        chk({tag, "_valid_W"}, N'(valid_W), '0);
        chk({tag, "_aluResult_W"}, aluResult_W, '0);
        chk({tag, "_readData_W"}, readData_W, '0);
        chk({tag, "_align_err_W"}, N'(align_err_W), '0);
        chk({tag, "_bus_err_W"}, N'(bus_err_W), '0);
        chk({tag, "_mem_addr"}, mem_addr, '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
        chk({tag, "_mem_we"}, N'(mem_we), '0);
    endtask

    initial begin
        reset       = 1'b1;
        aluResult_M = '0;
        writeData_M = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;

        // Directed cases.
        issue(1, 0, 0, 0, 0, 64'h2A, 64'h0, 0, '0);
        issue(1, 1, 0, 0, 0, 64'h100, 64'h77, 3, 64'hDEADBEEF);
        issue(1, 0, 1, 0, 0, 64'h8, 64'h55, 0, '0);
        issue(1, 0, 0, 1, 1, 64'h10, 64'h0, 0, '0);
        issue(1, 0, 1, 0, 0, 64'h104, 64'h99, 0, '0);
        issue(1, 1, 0, 0, 0, 64'h300, 64'h0, int'(TIMEOUT) + 2, 64'h1234);
        issue(1, 0, 0, 0, 1, 64'h40, 64'h0, 0, '0);
        issue(1, 1, 0, 0, 0, 64'h308, 64'h0, int'(TIMEOUT) - 1, 64'hCAFE_F00D);
        issue(1, 1, 1, 0, 0, 64'h310, 64'hABCD, 1, 64'h5555);
        issue(1, 1, 0, 0, 0, 64'h318, 64'h0, 0, 64'h0BAD_0BAD_1111_2222);
        issue(0, 1, 0, 0, 0, 64'h320, 64'h0, 0, '0);

        // Reset in the middle of an access.
        valid_M     = 1'b1;
        MemRead_M   = 1'b1;
        MemWrite_M  = 1'b0;
        aluResult_M = 64'h200;
        req_q.push_back('{we: 1'b0, addr: 64'h200, wdata: writeData_M, delay: 100,
                          rdata: '0});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        req_q.delete();
        @(posedge clk);
        #1;

        // Randomized stream.
        for (int i = 0; i < 300; i++) begin
            int           kind;
            logic [N-1:0] a;
            logic         rd, wr;
            kind = int'($urandom_range(0, 5));
            a    = {$urandom, $urandom} & ~64'h7;
            rd   = 1'b0;
            wr   = 1'b0;
            unique case (kind)
                0: ;
                1: begin rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1)); end
                2: rd = 1'b1;
                3: begin wr = 1'b1; rd = 1'($urandom_range(0, 1)); end
                4: begin
                    a  = a | N'($urandom_range(1, 7));
                    rd = 1'($urandom_range(0, 1));
                    wr = ~rd;
                end
                default: ;
            endcase
            issue((kind != 1), rd, wr, (kind == 5) || ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                  int'($urandom_range(0, TIMEOUT + 1)), {$urandom, $urandom});
        end

        idle_inputs();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("exp_q_drained", N'(exp_q.size()), '0);
        chk("req_q_drained", N'(req_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
